fetch_queue: RTL and testbench

Decoupling buffer between the instruction-fetch stage and the decode stage. It accepts fetched `ifid_t` bundles (PC, PC+4, instruction) from fetch under a valid/ready handshake and stores them in order. It delivers them to decode under a second valid/ready handshake. A branch or jump redirect discards every buffered entry in one cycle.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/fetch_queue_mem.sv | 26 ++
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch/decode bundle and fetch queue sizing.
// Occupancy classes used by fetch_queue to drive its handshakes.
package pipeline_pkg;

    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } ifid_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    function automatic occ_e occ_of(input int cnt, input int depth);
        occ_e o;
        if (cnt == 0)
            o = OCC_EMPTY;
        else if (cnt >= depth)
            o = OCC_FULL;
        else
            o = OCC_PARTIAL;
        return o;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x ifid_t registers, one write port and an
// asynchronous read port. Contents are deliberately left unreset.
module fetch_queue_mem
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ifid_t         wdata,
    input  logic [AW-1:0] raddr,
    output ifid_t         rdata
);

    ifid_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch->decode decoupling queue with single-cycle flush.
// Define FETCH_QUEUE_BYPASS_EN for zero-latency pass-through when empty.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid_i,
    input  ifid_t                    push_data_i,
    output logic                     push_ready_o,
    output logic                     pop_valid_o,
    output ifid_t                    pop_data_o,
    input  logic                     pop_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    ifid_t         rd_data;
    occ_e          occ;
    logic          push_fire;
    logic          pop_fire;
    logic          byp;

    assign occ     = occ_of(int'(count), DEPTH);
    assign count_o = count;

    always_comb begin
        push_ready_o = (occ != OCC_FULL) && !flush_i;
        pop_valid_o  = (occ != OCC_EMPTY) && !flush_i;
        pop_data_o   = '0;
        byp          = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty queue forwards fetch straight to decode; only a
        // consumed bundle skips storage.
        if (occ == OCC_EMPTY && !flush_i) begin
            pop_valid_o = push_valid_i;
            byp         = push_valid_i && pop_ready_i;
        end
        if (pop_valid_o)
            pop_data_o = (occ == OCC_EMPTY) ? push_data_i : rd_data;
`else
        if (pop_valid_o)
            pop_data_o = rd_data;
`endif
        push_fire = push_valid_i && push_ready_o && !byp;
        pop_fire  = pop_valid_o && pop_ready_i && !byp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_fire)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_fire),
        .waddr (wr_ptr),
        .wdata (push_data_i),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_fetch_queue;
    import pipeline_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        push_valid_i;
    ifid_t       push_data_i;
    logic        push_ready_o;
    logic        pop_valid_o;
    ifid_t       pop_data_o;
    logic        pop_ready_i;
    logic        flush_i;
    logic [2:0]  count_o;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (push_valid_i),
        .push_data_i  (push_data_i),
        .push_ready_o (push_ready_o),
        .pop_valid_o  (pop_valid_o),
        .pop_data_o   (pop_data_o),
        .pop_ready_i  (pop_ready_i),
        .flush_i      (flush_i),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ifid_t       mq[$];
    ifid_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        exp_pr;
    logic        exp_pv;
    ifid_t       exp_data;
    int          exp_cnt;
    bit          chk_en = 1'b0;
    logic [31:0] pc_n = 32'h0;

    function automatic ifid_t mk(input logic [31:0] pc);
        ifid_t b;
        b.pc       = pc;
        b.pc_plus4 = pc + 32'd4;
        b.instr    = $urandom;
        return b;
    endfunction

    task automatic chk(input string n, input logic [95:0] got,
                       input logic [95:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, got, want, $time);
        end
    endtask

    // One cycle of stimulus; the model decides what must happen.
    task automatic step(input logic pv, input ifid_t d,
                        input logic pr, input logic fl);
        bit empty;
        bit pf;
        bit qf;
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        push_valid_i = pv;
        push_data_i  = d;
        pop_ready_i  = pr;
        flush_i      = fl;
        empty    = (mq.size() == 0);
        exp_cnt  = mq.size();
        exp_pr   = (mq.size() != DEPTH) && !fl;
        exp_pv   = !fl && (!empty || (BYP && pv));
        exp_data = '0;
        if (exp_pv)
            exp_data = empty ? d : mq[0];
        pf = exp_pv && pr;
        qf = pv && exp_pr;
        if (pf)
            exp_q.push_back(exp_data);
        if (fl) begin
            mq.delete();
        end else begin
            if (pf && empty)
                qf = 1'b0;
            else if (pf)
                void'(mq.pop_front());
            if (qf)
                mq.push_back(d);
        end
        chk_en = 1'b1;
    endtask

    task automatic push(input logic pr, input logic fl);
        step(1'b1, mk(pc_n), pr, fl);
        pc_n += 32'd4;
    endtask

    task automatic idle(input logic pr);
        step(1'b0, mk(32'hdead_0000), pr, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        push_valid_i = 1'b0;
        push_data_i  = '0;
        pop_ready_i  = 1'b0;
        flush_i      = 1'b0;
        mq.delete();
        exp_q.delete();
        exp_cnt  = 0;
        exp_pr   = 1'b1;
        exp_pv   = 1'b0;
        exp_data = '0;
        chk_en   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        ifid_t e;
        if (chk_en) begin
            chk("push_ready", 96'(push_ready_o), 96'(exp_pr));
            chk("pop_valid", 96'(pop_valid_o), 96'(exp_pv));
            chk("count", 96'(count_o), 96'(exp_cnt));
            chk("pop_data", pop_data_o, exp_data);
            if (pop_valid_o && pop_ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_pop got=%h want=none", pop_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (pop_data_o !== e) begin
                        bad++;
                        $display("FAIL sb_data got=%h want=%h",
                                 pop_data_o, e);
                    end
                end
            end
        end
    end

    initial begin
        ifid_t held;
        rst_n        = 1'b0;
        push_valid_i = 1'b0;
        push_data_i  = '0;
        pop_ready_i  = 1'b0;
        flush_i      = 1'b0;

        do_reset();
        idle(1'b0);
        idle(1'b1);

        // ordering: fill to FULL, then drain
        pc_n = 32'h0;
        repeat (4) push(1'b0, 1'b0);
        idle(1'b0);
        repeat (5) idle(1'b1);

        // FULL with simultaneous push and pop
        repeat (4) push(1'b0, 1'b0);
        held = mk(pc_n);
        pc_n += 32'd4;
        step(1'b1, held, 1'b1, 1'b0);
        step(1'b1, held, 1'b1, 1'b0);
        repeat (5) idle(1'b1);

        // wrap-around streaming
        repeat (10) push(1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // flush at count 3 with push and pop asserted
        repeat (3) push(1'b0, 1'b0);
        push(1'b1, 1'b1);
        repeat (3) idle(1'b1);

        // bypass / latency on empty queue
        step(1'b1, mk(32'h40), 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        // reset in the middle of traffic
        repeat (2) push(1'b0, 1'b0);
        do_reset();
        repeat (2) idle(1'b1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, mk(pc_n), $urandom % 2,
                 ($urandom % 16) == 0);
            pc_n += 32'd4;
        end
        repeat (6) idle(1'b1);
        idle(1'b0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
